ahb_dm_slave: RTL and testbench

AHB_DM_SLAVE -- requirements
Module: ahb_dm_slave

---
 rtl/ahb_dm_slave.sv | 147 ++++++++++++++
 tb/tb_ahb_dm_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dm_slave.sv
// AHB-Lite slave bridging a single-port synchronous data memory (1-cycle read latency).
// Optional alignment/size error responses are enabled by defining DM_SLAVE_ERR_EN.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_dm_slave (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       HSel,
   input  logic [31:0]                HAddress,
   input  logic [`AHB_TRANS_BITS-1:0] HTrans,
   input  logic [`AHB_SIZE_BITS-1:0]  HSize,
   input  logic                       HWrite,
   input  logic [31:0]                HWrite_data,
   input  logic                       HReady,
   output logic                       HReady_out,
   output logic [1:0]                 HResp,
   output logic [31:0]                HRead_data,
   output logic                       DM_cs,
   output logic                       DM_oe,
   output logic [3:0]                 DM_web,
   output logic [13:0]                DM_addr,
   output logic [31:0]                DM_wdata,
   input  logic [31:0]                DM_rdata
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR      = 3'd1;
   localparam logic [2:0] ST_RD_WAIT = 3'd2;
   localparam logic [2:0] ST_RD_DONE = 3'd3;
   localparam logic [2:0] ST_ERR1    = 3'd4;
   localparam logic [2:0] ST_ERR2    = 3'd5;

   logic [2:0]  state_r;
   logic [2:0]  next_s;
   logic [15:0] addr_r;
   logic [2:0]  size_r;
   logic        write_r;
   logic        open_s;
   logic        accept_s;
   logic        err_s;
   logic        unused_s;

   // Active-low write-enable lanes; misaligned low bits are ignored (forced to lane 0 of the unit).
   function automatic logic [3:0] lane_web(input logic [2:0] size, input logic [1:0] lo);
      logic [3:0] web;
      web = 4'b1111;
      case (size)
         3'b000:  web[lo] = 1'b0;
         3'b001:  begin
            web[{lo[1], 1'b0}] = 1'b0;
            web[{lo[1], 1'b1}] = 1'b0;
         end
         default: web = 4'b0000;
      endcase
      return web;
   endfunction

   assign unused_s = ^{HAddress[31:16], HTrans[0]};
   assign open_s   = (state_r == ST_IDLE) || (state_r == ST_WR) ||
                     (state_r == ST_RD_DONE) || (state_r == ST_ERR2);
   assign accept_s = open_s && HSel && HReady && HTrans[1];

`ifdef DM_SLAVE_ERR_EN
   assign err_s = (HSize > 3'b010) ||
                  ((HSize == 3'b001) && HAddress[0]) ||
                  ((HSize == 3'b010) && (HAddress[1:0] != 2'b00));
`else
   assign err_s = 1'b0;
`endif

   // Next-state decode; every data-phase-complete state may pipeline straight into a new transfer.
   always_comb begin
      next_s = ST_IDLE;
      case (state_r)
         ST_IDLE, ST_WR, ST_RD_DONE, ST_ERR2: begin
            if (!accept_s)   next_s = ST_IDLE;
            else if (err_s)  next_s = ST_ERR1;
            else if (HWrite) next_s = ST_WR;
            else             next_s = ST_RD_WAIT;
         end
         ST_RD_WAIT: next_s = ST_RD_DONE;
         ST_ERR1:    next_s = ST_ERR2;
         default:    next_s = ST_IDLE;
      endcase
   end

   // State register and address-phase capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         addr_r  <= 16'h0000;
         size_r  <= 3'b000;
         write_r <= 1'b0;
      end else begin
         state_r <= next_s;
         if (accept_s) begin
            addr_r  <= HAddress[15:0];
            size_r  <= HSize;
            write_r <= HWrite;
         end else begin
            addr_r  <= addr_r;
            size_r  <= size_r;
            write_r <= write_r;
         end
      end
   end

   // Bus and memory outputs decoded from the current data-phase state.
   always_comb begin
      HReady_out = 1'b1;
      HResp      = 2'b00;
      HRead_data = 32'h0000_0000;
      DM_cs      = 1'b0;
      DM_oe      = 1'b0;
      DM_web     = 4'b1111;
      DM_addr    = addr_r[15:2];
      DM_wdata   = 32'h0000_0000;
      case (state_r)
         ST_WR: begin
            DM_cs    = 1'b1;
            DM_wdata = HWrite_data;
            if (write_r) DM_web = lane_web(size_r, addr_r[1:0]);
            else         DM_web = 4'b1111;
         end
         ST_RD_WAIT: begin
            DM_cs      = 1'b1;
            DM_oe      = 1'b1;
            HReady_out = 1'b0;
         end
         ST_RD_DONE: HRead_data = DM_rdata;
`ifdef DM_SLAVE_ERR_EN
         ST_ERR1: begin
            HResp      = 2'b01;
            HReady_out = 1'b0;
         end
         ST_ERR2: HResp = 2'b01;
`endif
         default: HReady_out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_ahb_dm_slave.sv
// Directed self-checking bench for ahb_dm_slave with a behavioral synchronous memory.
`timescale 1ns/1ps
module tb_ahb_dm_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        HSel;
   logic [31:0] HAddress;
   logic [1:0]  HTrans;
   logic [2:0]  HSize;
   logic        HWrite;
   logic [31:0] HWrite_data;
   logic        HReady;
   logic        HReady_out;
   logic [1:0]  HResp;
   logic [31:0] HRead_data;
   logic        DM_cs;
   logic        DM_oe;
   logic [3:0]  DM_web;
   logic [13:0] DM_addr;
   logic [31:0] DM_wdata;
   logic [31:0] DM_rdata;

   logic [31:0] mem [0:16383];
   int          wr_count = 0;
   int          checks = 0;
   int          failures = 0;
   logic [8:0]  ctl;

   localparam logic [8:0] CTL_IDLE = 9'b1_00_0_0_1111;
   localparam logic [8:0] CTL_RDW  = 9'b0_00_1_1_1111;

   always #5 clk = ~clk;
   assign HReady = HReady_out;
   assign ctl = {HReady_out, HResp, DM_cs, DM_oe, DM_web};

   ahb_dm_slave dut (
      .clk(clk), .rst(rst), .HSel(HSel), .HAddress(HAddress), .HTrans(HTrans),
      .HSize(HSize), .HWrite(HWrite), .HWrite_data(HWrite_data), .HReady(HReady),
      .HReady_out(HReady_out), .HResp(HResp), .HRead_data(HRead_data),
      .DM_cs(DM_cs), .DM_oe(DM_oe), .DM_web(DM_web), .DM_addr(DM_addr),
      .DM_wdata(DM_wdata), .DM_rdata(DM_rdata)
   );

   // Synchronous memory: read data appears the cycle after cs&oe, byte-lane writes on web low.
   always @(posedge clk) begin
      if (DM_cs && DM_oe) DM_rdata <= mem[DM_addr];
      if (DM_cs) begin
         for (int i = 0; i < 4; i++)
            if (!DM_web[i]) mem[DM_addr][i*8 +: 8] <= DM_wdata[i*8 +: 8];
         if (DM_web != 4'b1111) wr_count <= wr_count + 1;
      end
   end

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
      HSel = 1'b1; HAddress = a; HWrite = w; HSize = sz; HTrans = 2'b10;
   endtask

   task automatic idle_bus();
      HSel = 1'b0; HTrans = 2'b00;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] sz, input logic [3:0] exp_web);
      @(negedge clk); addr_phase(a, 1'b1, sz);
      @(negedge clk); idle_bus(); HWrite_data = d; #1;
      checks++;
      if (ctl !== {5'b1_00_1_0, exp_web} || DM_addr !== a[15:2] || DM_wdata !== d) begin
         failures++;
         $display("FAIL write_phase a=%h: got ctl=%b addr=%h wdata=%h, need ctl=%b addr=%h wdata=%h",
                  a, ctl, DM_addr, DM_wdata, {5'b1_00_1_0, exp_web}, a[15:2], d);
      end
      @(negedge clk); #1;
      checks++;
      if (ctl !== CTL_IDLE) begin
         failures++;
         $display("FAIL write_end a=%h: got ctl=%b, need %b", a, ctl, CTL_IDLE);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp);
      @(negedge clk); addr_phase(a, 1'b0, sz);
      @(negedge clk); idle_bus(); #1;
      checks++;
      if (ctl !== CTL_RDW || DM_addr !== a[15:2] || HRead_data !== 32'h0) begin
         failures++;
         $display("FAIL read_wait a=%h: got ctl=%b addr=%h rdata=%h, need ctl=%b addr=%h rdata=0",
                  a, ctl, DM_addr, HRead_data, CTL_RDW, a[15:2]);
      end
      @(negedge clk); #1;
      checks++;
      if (ctl !== CTL_IDLE || HRead_data !== exp) begin
         failures++;
         $display("FAIL read_done a=%h: got ctl=%b rdata=%h, need ctl=%b rdata=%h",
                  a, ctl, HRead_data, CTL_IDLE, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; idle_bus(); HAddress = 32'h0; HWrite = 1'b0; HSize = 3'b000; HWrite_data = 32'h0;
      #12;
      checks++;
      if (ctl !== CTL_IDLE || DM_addr !== 14'h0 || DM_wdata !== 32'h0 || HRead_data !== 32'h0) begin
         failures++;
         $display("FAIL reset: got ctl=%b addr=%h wdata=%h rdata=%h, need ctl=%b and zeros",
                  ctl, DM_addr, DM_wdata, HRead_data, CTL_IDLE);
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_lanes();
      do_write(32'h0000_0010, 32'hDEADBEEF, 3'b010, 4'b0000);
      do_read (32'h0000_0010, 3'b010, 32'hDEADBEEF);
      do_write(32'h0000_0013, 32'hAA00_0000, 3'b000, 4'b0111);
      do_read (32'h0000_0010, 3'b010, 32'hAAADBEEF);
      do_write(32'h0000_0012, 32'h1234_0000, 3'b001, 4'b0011);
      do_write(32'h0000_0011, 32'h0000_5500, 3'b000, 4'b1101);
      do_read (32'h0000_0010, 3'b010, 32'h123455EF);
   endtask

   task automatic test_back_to_back();
      @(negedge clk); addr_phase(32'h0000_0020, 1'b1, 3'b010);
      @(negedge clk); HWrite_data = 32'hCAFEF00D; addr_phase(32'h0000_0020, 1'b0, 3'b010); #1;
      checks++;
      if (ctl !== 9'b1_00_1_0_0000 || DM_wdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL b2b_write: got ctl=%b wdata=%h, need ctl=%b wdata=cafef00d",
                  ctl, DM_wdata, 9'b1_00_1_0_0000);
      end
      @(negedge clk); idle_bus(); #1;
      checks++;
      if (ctl !== CTL_RDW) begin
         failures++;
         $display("FAIL b2b_rdwait: got ctl=%b, need %b", ctl, CTL_RDW);
      end
      @(negedge clk); #1;
      checks++;
      if (ctl !== CTL_IDLE || HRead_data !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL b2b_rddone: got ctl=%b rdata=%h, need ctl=%b rdata=cafef00d",
                  ctl, HRead_data, CTL_IDLE);
      end
   endtask

   task automatic test_ignore();
      int cnt;
      cnt = wr_count;
      @(negedge clk); HSel = 1'b0; HTrans = 2'b10; HWrite = 1'b1; HAddress = 32'h10; HSize = 3'b010;
      @(negedge clk); HSel = 1'b1; HTrans = 2'b01; #1;
      checks++;
      if (ctl !== CTL_IDLE) begin
         failures++;
         $display("FAIL ignore_unsel: got ctl=%b, need %b", ctl, CTL_IDLE);
      end
      @(negedge clk); idle_bus(); #1;
      checks++;
      if (ctl !== CTL_IDLE || wr_count !== cnt) begin
         failures++;
         $display("FAIL ignore_busy: got ctl=%b writes=%0d, need ctl=%b writes=%0d",
                  ctl, wr_count, CTL_IDLE, cnt);
      end
   endtask

   task automatic test_misaligned();
`ifdef DM_SLAVE_ERR_EN
      @(negedge clk); addr_phase(32'h0000_0012, 1'b0, 3'b010);
      @(negedge clk); idle_bus(); #1;
      checks++;
      if (ctl !== 9'b0_01_0_0_1111) begin
         failures++;
         $display("FAIL err1: got ctl=%b, need %b", ctl, 9'b0_01_0_0_1111);
      end
      @(negedge clk); #1;
      checks++;
      if (ctl !== 9'b1_01_0_0_1111) begin
         failures++;
         $display("FAIL err2: got ctl=%b, need %b", ctl, 9'b1_01_0_0_1111);
      end
      @(negedge clk); #1;
      checks++;
      if (ctl !== CTL_IDLE) begin
         failures++;
         $display("FAIL err_end: got ctl=%b, need %b", ctl, CTL_IDLE);
      end
`else
      do_read(32'h0000_0012, 3'b010, 32'h123455EF);
`endif
   endtask

   task automatic test_reset_abort();
      int cnt;
      @(negedge clk); addr_phase(32'h0000_0010, 1'b0, 3'b010);
      @(negedge clk); idle_bus(); rst = 1'b0; #1;
      checks++;
      if (ctl !== CTL_IDLE || HRead_data !== 32'h0) begin
         failures++;
         $display("FAIL rst_in_rdwait: got ctl=%b rdata=%h, need ctl=%b rdata=0", ctl, HRead_data, CTL_IDLE);
      end
      @(negedge clk); rst = 1'b1;
      cnt = wr_count;
      @(negedge clk); addr_phase(32'h0000_0030, 1'b1, 3'b010);
      @(negedge clk); idle_bus(); HWrite_data = 32'h5555_5555; rst = 1'b0; #1;
      checks++;
      if (ctl !== CTL_IDLE) begin
         failures++;
         $display("FAIL rst_in_wr: got ctl=%b, need %b", ctl, CTL_IDLE);
      end
      @(negedge clk); rst = 1'b1; #1;
      checks++;
      if (wr_count !== cnt || mem[12] !== 32'h0) begin
         failures++;
         $display("FAIL rst_abort_nowrite: got writes=%0d mem=%h, need writes=%0d mem=0",
                  wr_count, mem[12], cnt);
      end
      do_write(32'h0000_0030, 32'h0BADF00D, 3'b010, 4'b0000);
      do_read (32'h0000_0030, 3'b010, 32'h0BADF00D);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      test_reset();
      test_lanes();
      test_back_to_back();
      test_ignore();
      test_misaligned();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
